// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Multiplexed 7-segment scan driver with frame-synchronous
//            double-buffered display data and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [7:0]              hex,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    pending
);

    localparam logic [15:0] c_DIV_LAST = 16'(DIV - 1);
    localparam logic [2:0]  c_IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [15:0]             r_div;
    logic [2:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_bcd;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_act_blz;
    logic [4*NUM_DIGITS-1:0] r_sh_bcd;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_blz;
    logic                    r_pending;
    logic [7:0]              r_hex;
    logic [NUM_DIGITS-1:0]   r_dig_sel;
    logic                    r_frame_done;

    logic                    w_tc;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_hi_zero;
    logic [7:0]              w_dhex [NUM_DIGITS];
    logic [7:0]              w_sel_hex;
    logic [NUM_DIGITS-1:0]   w_sel_dig;

    function automatic logic [6:0] f_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h18;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tc   = en && (r_div == c_DIV_LAST);
    assign w_wrap = w_tc && (r_idx == c_IDX_LAST);

    // w_hi_zero[i]: digit i and every more significant digit are zero
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_hi_zero[gi] = (r_act_bcd[4*gi +: 4] == 4'd0);
            end else begin : g_low
                assign w_hi_zero[gi] = (r_act_bcd[4*gi +: 4] == 4'd0) && w_hi_zero[gi+1];
            end

            if (gi == 0) begin : g_lsd
                assign w_dhex[gi] = {~r_act_dp[gi], f_seg(r_act_bcd[4*gi +: 4])};
            end else begin : g_msd
                assign w_dhex[gi] = {~r_act_dp[gi],
                                     (r_act_blz && w_hi_zero[gi]) ? 7'h7F
                                                                  : f_seg(r_act_bcd[4*gi +: 4])};
            end
        end
    endgenerate

    always_comb begin
        w_sel_hex = 8'hFF;
        w_sel_dig = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_sel_hex    = w_dhex[i];
                w_sel_dig[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (en) begin
            if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_div <= r_div + 16'd1;
            end
        end
    end

    // Active buffer only changes at the frame wrap, so a frame is never mixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_bcd <= '1;
            r_act_dp  <= '0;
            r_act_blz <= 1'b0;
            r_sh_bcd  <= '1;
            r_sh_dp   <= '0;
            r_sh_blz  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_act_bcd <= r_sh_bcd;
                r_act_dp  <= r_sh_dp;
                r_act_blz <= r_sh_blz;
            end
            if (load) begin
                r_sh_bcd <= bcd;
                r_sh_dp  <= dp;
                r_sh_blz <= blank_lz;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex        <= 8'hFF;
            r_dig_sel    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (en) begin
                r_hex     <= w_sel_hex;
                r_dig_sel <= w_sel_dig;
            end else begin
                r_hex     <= 8'hFF;
                r_dig_sel <= '1;
            end
        end
    end

    assign hex        = r_hex;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed scoreboard bench for seg7_scan_driver (4 digits, DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [7:0]  hex;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        pending;

    seg7_scan_driver #(.NUM_DIGITS(4), .DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd        (bcd),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .hex        (hex),
        .dig_sel    (dig_sel),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hex;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t  q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    string cur_tag     = "";

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [7:0] eh, input logic [3:0] ed, input logic efd);
        exp_t e;
        e.hex = eh;
        e.dig = ed;
        e.fd  = efd;
        q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        vectors++;
        assert (q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s scoreboard: observed empty queue, expected an entry", cur_tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            assert (hex === e.hex) else begin
                miscompares++;
                $error("FAIL %s hex: observed %h expected %h", cur_tag, hex, e.hex);
            end
            vectors++;
            assert (dig_sel === e.dig) else begin
                miscompares++;
                $error("FAIL %s dig_sel: observed %b expected %b", cur_tag, dig_sel, e.dig);
            end
            vectors++;
            assert (frame_done === e.fd) else begin
                miscompares++;
                $error("FAIL %s frame_done: observed %b expected %b", cur_tag, frame_done, e.fd);
            end
        end
    endtask

    task automatic step(input logic [7:0] eh, input logic [3:0] ed, input logic efd);
        expect_out(eh, ed, efd);
        tick();
        compare_out();
    endtask

    task automatic chk_pend(input logic ep);
        vectors++;
        assert (pending === ep) else begin
            miscompares++;
            $error("FAIL %s pending: observed %b expected %b", cur_tag, pending, ep);
        end
    endtask

    // pkt layout: {blank_lz, dp[3:0], bcd[15:0]}
    task automatic drive(input logic [20:0] pkt);
        bcd      = pkt[15:0];
        dp       = pkt[19:16];
        blank_lz = pkt[20];
        load     = 1'b1;
    endtask

    // One full 16-clock frame; hexes = {digit3, digit2, digit1, digit0}
    task automatic frame(input string tag, input logic [31:0] hexes,
                         input int ls1, input logic [20:0] p1,
                         input int ls2, input logic [20:0] p2,
                         input logic pmid, input logic pend_end);
        cur_tag = tag;
        for (int j = 0; j < 16; j++) begin
            if (j == ls1)      drive(p1);
            else if (j == ls2) drive(p2);
            else               load = 1'b0;
            step(hexes[8*(j/4) +: 8], ~(4'b0001 << (j/4)), (j == 15));
            if (j == 7) chk_pend(pmid);
        end
        load = 1'b0;
        chk_pend(pend_end);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        bcd      = 16'h0000;
        dp       = 4'h0;
        blank_lz = 1'b0;

        repeat (3) tick();
        cur_tag = "reset";
        expect_out(8'hFF, 4'hF, 1'b0);
        compare_out();
        chk_pend(1'b0);

        rst_n = 1'b1;
        en    = 1'b1;
        frame("rst_scan", 32'hFFFF_FFFF, -1, 21'h0, -1, 21'h0, 1'b0, 1'b0);
        frame("load_1234", 32'hFFFF_FFFF, 0, {1'b0, 4'b0000, 16'h1234}, -1, 21'h0, 1'b1, 1'b0);
        frame("show_1234", 32'hF9A4_B099, 0, {1'b1, 4'b0100, 16'h0070}, -1, 21'h0, 1'b1, 1'b0);
        frame("blank_dp", 32'hFF7F_F8C0, 0, {1'b0, 4'b0000, 16'h1111},
              15, {1'b0, 4'b0000, 16'h2222}, 1'b1, 1'b1);
        frame("collide_1111", 32'hF9F9_F9F9, -1, 21'h0, -1, 21'h0, 1'b1, 1'b0);
        frame("show_2222", 32'hA4A4_A4A4, 0, {1'b0, 4'b0000, 16'hABCD}, -1, 21'h0, 1'b1, 1'b0);
        frame("invalid", 32'hFFFF_FFFF, -1, 21'h0, -1, 21'h0, 1'b0, 1'b0);

        cur_tag = "freeze";
        for (int j = 0; j < 5; j++) step(8'hFF, ~(4'b0001 << (j/4)), 1'b0);
        en = 1'b0;
        drive({1'b0, 4'b0000, 16'h5678});
        step(8'hFF, 4'hF, 1'b0);
        load = 1'b0;
        chk_pend(1'b1);
        step(8'hFF, 4'hF, 1'b0);
        step(8'hFF, 4'hF, 1'b0);
        en = 1'b1;
        cur_tag = "resume";
        for (int j = 5; j < 16; j++) step(8'hFF, ~(4'b0001 << (j/4)), (j == 15));
        chk_pend(1'b0);

        frame("show_5678", 32'h9282_F880, -1, 21'h0, -1, 21'h0, 1'b0, 1'b0);

        cur_tag = "pre_reset";
        drive({1'b0, 4'b0000, 16'h9999});
        step(8'h80, 4'b1110, 1'b0);
        load = 1'b0;
        for (int j = 1; j < 9; j++) begin
            step((j < 4) ? 8'h80 : (j < 8) ? 8'hF8 : 8'h82, ~(4'b0001 << (j/4)), 1'b0);
        end
        chk_pend(1'b1);

        cur_tag = "mid_reset";
        rst_n = 1'b0;
        #1;
        expect_out(8'hFF, 4'hF, 1'b0);
        compare_out();
        chk_pend(1'b0);
        step(8'hFF, 4'hF, 1'b0);
        step(8'hFF, 4'hF, 1'b0);
        rst_n = 1'b1;
        frame("post_reset", 32'hFFFF_FFFF, -1, 21'h0, -1, 21'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 The block SHALL have parameter DIV, default 1000: clock cycles each digit is driven; legal range 2..65535.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port en  input  1  scan enable.
REQ-006 The block SHALL have port load  input  1  one-cycle strobe capturing bcd, dp and blank_lz.
REQ-007 The block SHALL have port bcd  input  4*NUM_DIGITS  digit values; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-008 The block SHALL have port dp  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-009 The block SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 The block SHALL have port hex  output  8  active-low segments; bit 7 = DP, bits 6:0 = g..a.
REQ-011 The block SHALL have port dig_sel  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse at frame wrap.
REQ-013 The block SHALL have port pending  output  1  high while captured data awaits frame-boundary apply.

Function
REQ-014 Segment code (bits 6:0, bit 7 = 1 when DP off) SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, 10..15=FF (blank).
REQ-015 Divider SHALL count 0..DIV-1 while en=1; at terminal count it SHALL reset to 0 and advance digit index idx.
REQ-016 idx SHALL advance 0,1,...,NUM_DIGITS-1 and then wrap to 0.
REQ-017 frame_done SHALL be 1 for exactly the one cycle following the edge on which idx wraps NUM_DIGITS-1 -> 0.
REQ-018 hex and dig_sel SHALL be registered, reflecting idx and the active buffer with one-cycle latency.
REQ-019 dig_sel SHALL have bit idx = 0 and all other bits 1 when en=1.
REQ-020 load=1 SHALL copy bcd, dp and blank_lz into a shadow buffer and set pending=1 on the next edge.
REQ-021 A repeated load while pending=1 SHALL overwrite the shadow buffer, last load wins.
REQ-022 At the wrap edge with pending=1, the shadow buffer SHALL move into the active buffer and pending SHALL clear.
REQ-023 If load and the wrap coincide, the previous shadow SHALL become active; the new data SHALL enter the shadow; pending SHALL remain 1.
REQ-024 Display SHALL never show mixed old/new data within one frame.
REQ-025 With active blank_lz=1, digit i>0 SHALL show FF in bits 6:0 when it and every higher digit equal 0.
REQ-026 Digit 0 SHALL never be blanked by the leading-zero rule.
REQ-027 hex bit 7 SHALL be 0 when the active dp bit for idx is 1, including on blanked digits.
REQ-028 en=0 SHALL freeze divider and idx and drive dig_sel all-ones and hex=FF from the next cycle.
REQ-029 load and pending SHALL still operate while en=0; a pending apply SHALL wait for the next wrap.
REQ-030 en 0 -> 1 SHALL resume from the frozen idx and divider value.

Reset
REQ-031 rst_n=0 SHALL immediately force hex=FF, dig_sel all-ones, frame_done=0 and pending=0.
REQ-032 rst_n=0 SHALL immediately clear idx and the divider to 0.
REQ-033 rst_n=0 SHALL set the active and shadow bcd to all 0xF, dp to 0 and blank_lz to 0, so the display is dark.
REQ-034 Reset SHALL apply mid-frame or mid-pending with no residual state.
REQ-035 The first digit-0 drive SHALL appear on the first edge after rst_n rises with en=1.

Verification (NUM_DIGITS=4, DIV=4)
REQ-036 Reset scenario: rst_n low -> hex=FF, dig_sel=1111, pending=0; release with en=1 -> dig_sel cycles 1110, 1101, 1011, 0111 every 4 clocks with hex=FF.
REQ-037 Basic scenario: load bcd=16'h1234, dp=0 -> pending=1 until wrap; next frame shows digit0 99, digit1 B0, digit2 A4, digit3 F9; frame_done pulses once per 16 clocks.
REQ-038 Blank/DP scenario: load bcd=16'h0070, blank_lz=1, dp=4'b0100 -> digit3 FF, digit2 7F, digit1 F8, digit0 C0.
REQ-039 Collision scenario: load 16'h1111 then 16'h2222 on the wrap cycle -> next frame shows all F9, pending stays 1; following frame shows all A4, pending 0.
REQ-040 Freeze/invalid scenario: bcd=16'hABCD -> all digits FF; en=0 mid-digit -> dig_sel=1111 next cycle; en=1 -> scan resumes at the same digit with its remaining count.
REQ-041 Mid-frame reset scenario: rst_n pulse at idx=2 -> outputs dark immediately; shadow cleared; scan restarts at digit 0.
